// File: rtl/mcu_xbus_pkg.sv
// Shared types and constants for the MCU external-bus arbiter.
package mcu_xbus_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    // Slave selected for the access in flight.
    typedef enum logic [1:0] {
        TGT_RAM = 2'd0,
        TGT_APB = 2'd1,
        TGT_REG = 2'd2
    } target_e;

    // Register-window offsets (address bits [3:0]).
    localparam logic [3:0] OFF_FIFO     = 4'd0;
    localparam logic [3:0] OFF_STATUS   = 4'd1;
    localparam logic [3:0] OFF_REG_BASE = 4'd2;

    // Status register bit positions.
    localparam int STAT_FULL_BIT = 0;
    localparam int STAT_TO_BIT   = 1;
    localparam int STAT_OVF_BIT  = 2;

    // Data returned to the CPU when a slave never answers.
    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

    // Code fetches always go to RAM; data accesses are split by the window bits.
    function automatic target_e decode_target(input logic is_code,
                                              input logic win_sel,
                                              input logic reg_sel);
        target_e tgt;
        if (is_code || !win_sel) begin
            tgt = TGT_RAM;
        end else if (!reg_sel) begin
            tgt = TGT_APB;
        end else begin
            tgt = TGT_REG;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/mcu_xbus_regfile.sv
// Register window: FIFO push port, sticky status bits and general byte registers.
// Writes and reads are resolved on the same edge the arbiter accepts the access.
module mcu_xbus_regfile
    import mcu_xbus_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [3:0]            off_i,
    input  logic [7:0]            wdata_i,
    input  logic                  to_set_i,
    input  logic                  fifo_full_i,
    output logic [7:0]            rdata_o,
    output logic [8*NUM_REGS-1:0] regs_o,
    output logic                  fifo_wen_o,
    output logic [7:0]            fifo_wdata_o,
    output logic                  err_irq_o
);

    logic [NUM_REGS-1:0][7:0] file_q;
    logic                     to_q;
    logic                     ovf_q;
    logic                     err_irq_q;
    logic                     fifo_wen_q;
    logic [7:0]               fifo_wdata_q;

    logic push_req;
    logic push_ok;
    logic ovf_set;
    logic stat_wr;
    logic to_d;
    logic ovf_d;

    assign push_req = we_i && (off_i == OFF_FIFO);
    assign push_ok  = push_req && !fifo_full_i;
    assign ovf_set  = push_req && fifo_full_i;
    assign stat_wr  = we_i && (off_i == OFF_STATUS);

    // Sticky status next-state: write-1-to-clear, a same-cycle set wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        to_d  = to_q;
        ovf_d = ovf_q;
        if (stat_wr && wdata_i[STAT_TO_BIT]) begin
            to_d = 1'b0;
        end
        if (stat_wr && wdata_i[STAT_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
        if (to_set_i) begin
            to_d = 1'b1;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    // Read mux: status, general registers, zero for FIFO and unmapped offsets.
    always_comb begin
        rdata_o = '0;
        if (off_i == OFF_STATUS) begin
            rdata_o[STAT_FULL_BIT] = fifo_full_i;
            rdata_o[STAT_TO_BIT]   = to_q;
            rdata_o[STAT_OVF_BIT]  = ovf_q;
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            if (off_i == OFF_REG_BASE + 4'(k)) begin
                rdata_o = file_q[k];
            end
        end
    end

    // Register file, status bits, FIFO push pulse and registered interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is architecturally visible on regs_o, so it is reset like any other state.
            file_q       <= '0;
            to_q         <= 1'b0;
            ovf_q        <= 1'b0;
            err_irq_q    <= 1'b0;
            fifo_wen_q   <= 1'b0;
            fifo_wdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            fifo_wen_q <= push_ok;
            if (push_ok) begin
                fifo_wdata_q <= wdata_i;
            end
            for (int k = 0; k < NUM_REGS; k++) begin
                if (we_i && (off_i == OFF_REG_BASE + 4'(k))) begin
                    file_q[k] <= wdata_i;
                end
            end
            to_q      <= to_d;
            ovf_q     <= ovf_d;
            err_irq_q <= to_q | ovf_q;
        end
    end

    assign regs_o       = file_q;
    assign fifo_wen_o   = fifo_wen_q;
    assign fifo_wdata_o = fifo_wdata_q;
    assign err_irq_o    = err_irq_q;

endmodule

// File: rtl/mcu_xbus_arbiter.sv
// MCU external-bus arbiter: routes CPU code/data strobes to PSRAM, the APB
// bridge or the local register window, with a per-access slave timeout.
module mcu_xbus_arbiter
    import mcu_xbus_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int TIMEOUT  = 255,
    parameter int WIN_BIT  = 17,
    parameter int REG_BIT  = 11
) (
    input  logic                  cpuclk,
    input  logic                  rstn,
    input  logic [22:0]           memaddr_comb,
    input  logic [7:0]            memdatao_comb,
    input  logic                  memrd_comb,
    input  logic                  memwr_comb,
    input  logic                  mempsrd_comb,
    input  logic                  mempswr_comb,
    output logic                  memack,
    output logic                  mempsack,
    output logic [7:0]            memdatai,
    output logic                  apb_rd,
    output logic                  apb_wr,
    input  logic                  apb_ack,
    input  logic [7:0]            apb_rdata,
    output logic                  ram_rd,
    output logic                  ram_wr,
    input  logic                  ram_ack,
    input  logic [7:0]            ram_rdata,
    output logic [8*NUM_REGS-1:0] regs_q,
    output logic [7:0]            fifo_wdata,
    output logic                  fifo_wen,
    input  logic                  fifo_full,
    output logic                  err_irq
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_e      state_q;
    target_e     tgt_q;
    logic        code_q;
    logic        write_q;
    logic [15:0] cnt_q;
    logic        memack_q;
    logic        mempsack_q;
    logic [7:0]  memdatai_q;
    logic        apb_rd_q;
    logic        apb_wr_q;
    logic        ram_rd_q;
    logic        ram_wr_q;

    logic        any_strobe;
    logic        req_code;
    logic        req_write;
    target_e     req_tgt;
    logic        accept;
    logic        reg_we;
    logic [7:0]  reg_rdata;
    logic        slave_ack;
    logic [7:0]  slave_rdata;
    logic        timeout_hit;
    logic        unused_addr;

    // Request decode; code strobes take priority over data strobes.
    assign any_strobe = mempsrd_comb | mempswr_comb | memrd_comb | memwr_comb;
    assign req_code   = mempsrd_comb | mempswr_comb;
    assign req_write  = req_code ? mempswr_comb : memwr_comb;
    assign req_tgt    = decode_target(req_code, memaddr_comb[WIN_BIT], memaddr_comb[REG_BIT]);
    assign accept     = (state_q == ST_IDLE) && any_strobe;
    assign reg_we     = accept && (req_tgt == TGT_REG) && req_write;

    // Only the offset and the two window bits take part in decode.
    assign unused_addr = ^memaddr_comb;

    // Response from whichever external slave owns the access in flight.
    assign slave_ack   = (tgt_q == TGT_APB) ? apb_ack   : ram_ack;
    assign slave_rdata = (tgt_q == TGT_APB) ? apb_rdata : ram_rdata;
    assign timeout_hit = (state_q == ST_BUSY) && !slave_ack && (cnt_q == TIMEOUT_CNT);

    mcu_xbus_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk          (cpuclk),
        .rst_n        (rstn),
        .we_i         (reg_we),
        .off_i        (memaddr_comb[3:0]),
        .wdata_i      (memdatao_comb),
        .to_set_i     (timeout_hit),
        .fifo_full_i  (fifo_full),
        .rdata_o      (reg_rdata),
        .regs_o       (regs_q),
        .fifo_wen_o   (fifo_wen),
        .fifo_wdata_o (fifo_wdata),
        .err_irq_o    (err_irq)
    );

    // Access FSM with registered CPU acks, read data and slave strobes.
    always_ff @(posedge cpuclk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            tgt_q      <= TGT_RAM;
            code_q     <= 1'b0;
            write_q    <= 1'b0;
            cnt_q      <= '0;
            memack_q   <= 1'b0;
            mempsack_q <= 1'b0;
            memdatai_q <= '0;
            apb_rd_q   <= 1'b0;
            apb_wr_q   <= 1'b0;
            ram_rd_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
        end else begin
            memack_q   <= 1'b0;
            mempsack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_strobe) begin
                        tgt_q   <= req_tgt;
                        code_q  <= req_code;
                        write_q <= req_write;
                        cnt_q   <= '0;
                        if (req_tgt == TGT_REG) begin
                            state_q  <= ST_ACK;
                            memack_q <= 1'b1;
                            if (!req_write) begin
                                memdatai_q <= reg_rdata;
                            end
                        end else begin
                            state_q  <= ST_BUSY;
                            ram_rd_q <= (req_tgt == TGT_RAM) && !req_write;
                            ram_wr_q <= (req_tgt == TGT_RAM) &&  req_write;
                            apb_rd_q <= (req_tgt == TGT_APB) && !req_write;
                            apb_wr_q <= (req_tgt == TGT_APB) &&  req_write;
                        end
                    end
                end
                ST_BUSY: begin
                    if (slave_ack || timeout_hit) begin
                        state_q    <= ST_ACK;
                        memack_q   <= !code_q;
                        mempsack_q <= code_q;
                        ram_rd_q   <= 1'b0;
                        ram_wr_q   <= 1'b0;
                        apb_rd_q   <= 1'b0;
                        apb_wr_q   <= 1'b0;
                        if (!slave_ack) begin
                            memdatai_q <= TIMEOUT_RDATA;
                        end else if (!write_q) begin
                            memdatai_q <= slave_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    // The CPU must release every strobe before another access is accepted.
                    if (!any_strobe) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign memack   = memack_q;
    assign mempsack = mempsack_q;
    assign memdatai = memdatai_q;
    assign apb_rd   = apb_rd_q;
    assign apb_wr   = apb_wr_q;
    assign ram_rd   = ram_rd_q;
    assign ram_wr   = ram_wr_q;

endmodule

// File: tb/tb_mcu_xbus_arbiter.sv
// Self-checking bench for mcu_xbus_arbiter: table-driven register-window
// vectors plus hand-written multi-cycle sequences, read data via a scoreboard.
`timescale 1ns/1ps
module tb_mcu_xbus_arbiter;

    localparam int NUM_REGS = 8;
    localparam int TIMEOUT  = 16;

    localparam logic [3:0] S_PSRD = 4'b1000;
    localparam logic [3:0] S_PSWR = 4'b0100;
    localparam logic [3:0] S_RD   = 4'b0010;
    localparam logic [3:0] S_WR   = 4'b0001;

    logic                  cpuclk = 1'b0;
    logic                  rstn;
    logic [22:0]           memaddr_comb;
    logic [7:0]            memdatao_comb;
    logic                  memrd_comb, memwr_comb, mempsrd_comb, mempswr_comb;
    logic                  memack, mempsack;
    logic [7:0]            memdatai;
    logic                  apb_rd, apb_wr, apb_ack;
    logic [7:0]            apb_rdata;
    logic                  ram_rd, ram_wr, ram_ack;
    logic [7:0]            ram_rdata;
    logic [8*NUM_REGS-1:0] regs_q;
    logic [7:0]            fifo_wdata;
    logic                  fifo_wen, fifo_full;
    logic                  err_irq;

    mcu_xbus_arbiter #(
        .NUM_REGS (NUM_REGS),
        .TIMEOUT  (TIMEOUT),
        .WIN_BIT  (17),
        .REG_BIT  (11)
    ) dut (
        .cpuclk        (cpuclk),
        .rstn          (rstn),
        .memaddr_comb  (memaddr_comb),
        .memdatao_comb (memdatao_comb),
        .memrd_comb    (memrd_comb),
        .memwr_comb    (memwr_comb),
        .mempsrd_comb  (mempsrd_comb),
        .mempswr_comb  (mempswr_comb),
        .memack        (memack),
        .mempsack      (mempsack),
        .memdatai      (memdatai),
        .apb_rd        (apb_rd),
        .apb_wr        (apb_wr),
        .apb_ack       (apb_ack),
        .apb_rdata     (apb_rdata),
        .ram_rd        (ram_rd),
        .ram_wr        (ram_wr),
        .ram_ack       (ram_ack),
        .ram_rdata     (ram_rdata),
        .regs_q        (regs_q),
        .fifo_wdata    (fifo_wdata),
        .fifo_wen      (fifo_wen),
        .fifo_full     (fifo_full),
        .err_irq       (err_irq)
    );

    always #5 cpuclk = ~cpuclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave models: ack once the strobe has been seen for *_lat cycles (0 = never).
    int         ram_lat = 1, apb_lat = 1;
    logic [7:0] ram_data = 8'h00, apb_data = 8'h00;
    int         ram_cnt = 0, apb_cnt = 0;

    always @(negedge cpuclk) begin
        if (ram_rd || ram_wr) begin
            ram_cnt++;
            ram_ack   = (ram_lat != 0) && (ram_cnt >= ram_lat);
            ram_rdata = ram_data;
        end else begin
            ram_cnt = 0;
            ram_ack = 1'b0;
        end
        if (apb_rd || apb_wr) begin
            apb_cnt++;
            apb_ack   = (apb_lat != 0) && (apb_cnt >= apb_lat);
            apb_rdata = apb_data;
        end else begin
            apb_cnt = 0;
            apb_ack = 1'b0;
        end
    end

    // FIFO push monitor: cycles with fifo_wen high and number of rising edges.
    int   wen_cycles = 0, wen_pulses = 0;
    logic wen_prev = 1'b0;
    always begin
        @(posedge cpuclk);
        #1;
        if (fifo_wen === 1'b1) wen_cycles++;
        if (fifo_wen === 1'b1 && wen_prev !== 1'b1) wen_pulses++;
        wen_prev = fifo_wen;
    end

    // Scoreboard of expected read data, pushed when a read is driven.
    logic [7:0] exp_q[$];

    int         lat, n_ram_rd, n_ram_wr, n_apb_rd, n_apb_wr;
    logic       ack_wen;
    logic [7:0] ack_wdata;

    // One CPU access; called just after a rising edge, returns with the FSM back in IDLE.
    task automatic access(input logic [3:0] strb, input logic [22:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input int hold_extra, input string name);
        bit         code, rd, got;
        int         extra_acks;
        logic [7:0] exp;
        code = strb[3] | strb[2];
        rd   = code ? strb[3] : strb[1];
        if (rd) exp_q.push_back(exp_rd);
        {mempsrd_comb, mempswr_comb, memrd_comb, memwr_comb} = strb;
        memaddr_comb  = addr;
        memdatao_comb = wd;
        lat = 0; n_ram_rd = 0; n_ram_wr = 0; n_apb_rd = 0; n_apb_wr = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge cpuclk);
            #1;
            lat++;
            n_ram_rd += int'(ram_rd);
            n_ram_wr += int'(ram_wr);
            n_apb_rd += int'(apb_rd);
            n_apb_wr += int'(apb_wr);
            if (memack || mempsack) got = 1'b1;
        end
        ack_wen   = fifo_wen;
        ack_wdata = fifo_wdata;
        if (!got) begin
            check({name, "_ack_seen"}, 64'd0, 64'd1);
            if (rd) void'(exp_q.pop_front());
        end else begin
            check({name, "_ack_kind"}, {62'd0, memack, mempsack}, code ? 64'd1 : 64'd2);
            if (rd) begin
                exp = exp_q.pop_front();
                check({name, "_rdata"}, memdatai, exp);
            end
        end
        extra_acks = 0;
        repeat (hold_extra) begin
            @(posedge cpuclk);
            #1;
            extra_acks += int'(memack | mempsack);
        end
        {mempsrd_comb, mempswr_comb, memrd_comb, memwr_comb} = 4'b0000;
        repeat (2) begin
            @(posedge cpuclk);
            #1;
            extra_acks += int'(memack | mempsack);
        end
        check({name, "_single_ack"}, extra_acks, 0);
    endtask

    // Register-window vectors: {write, offset, wdata, fifo_full, expected read, expected fifo_wen}.
    typedef struct {
        bit         wr;
        logic [3:0] off;
        logic [7:0] wd;
        bit         full;
        logic [7:0] exp_rd;
        bit         exp_wen;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, p0;

        vecs[0]  = '{1'b1, 4'd3,  8'hA5, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 4'd9,  8'h3C, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 4'd10, 8'hEE, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 4'd15, 8'h77, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 4'd3,  8'h00, 1'b0, 8'hA5, 1'b0};
        vecs[5]  = '{1'b0, 4'd9,  8'h00, 1'b0, 8'h3C, 1'b0};
        vecs[6]  = '{1'b0, 4'd10, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 4'd0,  8'h00, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 4'd1,  8'h00, 1'b1, 8'h01, 1'b0};
        vecs[9]  = '{1'b0, 4'd1,  8'h00, 1'b0, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 4'd4,  8'h00, 1'b0, 8'h00, 1'b0};

        rstn = 1'b0;
        {mempsrd_comb, mempswr_comb, memrd_comb, memwr_comb} = 4'b0000;
        memaddr_comb = '0; memdatao_comb = '0; fifo_full = 1'b0;
        apb_ack = 1'b0; apb_rdata = '0; ram_ack = 1'b0; ram_rdata = '0;
        repeat (3) @(posedge cpuclk);
        #1;
        check("reset_acks",    {memack, mempsack, fifo_wen, err_irq}, 4'b0000);
        check("reset_strobes", {apb_rd, apb_wr, ram_rd, ram_wr}, 4'b0000);
        check("reset_datai",   memdatai, 8'h00);
        check("reset_regs",    regs_q, 64'h0);
        check("reset_wdata",   fifo_wdata, 8'h00);
        @(negedge cpuclk);
        rstn = 1'b1;
        @(posedge cpuclk);
        #1;

        // Register write at offset 2, single-cycle latency, then read back.
        access(S_WR, 23'h020802, 8'h5A, 8'h00, 0, "reg2_wr");
        check("reg2_wr_lat", lat, 1);
        check("reg2_regs", regs_q[7:0], 8'h5A);
        access(S_RD, 23'h020802, 8'h00, 8'h5A, 3, "reg2_rd");
        check("reg2_rd_lat", lat, 1);

        // Table-driven register window sweep.
        for (int i = 0; i < NVEC; i++) begin
            fifo_full = vecs[i].full;
            access(vecs[i].wr ? S_WR : S_RD, 23'h020800 | {19'd0, vecs[i].off}, vecs[i].wd,
                   vecs[i].exp_rd, 0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_lat", i), lat, 1);
            check($sformatf("vec%0d_wen", i), ack_wen, vecs[i].exp_wen);
        end
        fifo_full = 1'b0;
        check("regs_image", regs_q, 64'h3C00_0000_0000_A55A);

        // RAM data read, slave acks after three cycles of ram_rd.
        ram_lat = 3; ram_data = 8'hC3;
        access(S_RD, 23'h000100, 8'h00, 8'hC3, 0, "ram_rd");
        check("ram_rd_lat", lat, 4);
        check("ram_rd_cycles", n_ram_rd, 3);
        check("ram_rd_no_apb", n_apb_rd + n_apb_wr, 0);
        repeat (3) @(posedge cpuclk);
        #1;
        check("ram_rd_datai_stable", memdatai, 8'hC3);

        // Code read and data read together on a register address: code wins, goes to RAM.
        ram_lat = 2; ram_data = 8'h96;
        access(S_PSRD | S_RD, 23'h020802, 8'h00, 8'h96, 0, "code_tie");
        check("code_tie_ram_cycles", n_ram_rd, 2);

        // Code write to RAM.
        ram_lat = 1;
        access(S_PSWR, 23'h000200, 8'h44, 8'h00, 0, "code_wr");
        check("code_wr_cycles", n_ram_wr, 1);

        // APB write and read with prompt acks.
        apb_lat = 2; apb_data = 8'h9E;
        access(S_WR, 23'h020010, 8'h21, 8'h00, 0, "apb_wr");
        check("apb_wr_cycles", n_apb_wr, 2);
        apb_lat = 1;
        access(S_RD, 23'h020010, 8'h00, 8'h9E, 0, "apb_rd");
        check("apb_rd_lat", lat, 2);
        check("apb_rd_irq", err_irq, 1'b0);

        // APB read that is never acknowledged: forced ack with 8'hFF after TIMEOUT.
        apb_lat = 0;
        access(S_RD, 23'h020004, 8'h00, 8'hFF, 0, "apb_to");
        check("apb_to_lat", lat, TIMEOUT + 2);
        check("apb_to_strobe_cycles", n_apb_rd, TIMEOUT + 1);
        check("apb_to_strobe_dropped", apb_rd, 1'b0);
        check("apb_to_irq", err_irq, 1'b1);
        access(S_RD, 23'h020801, 8'h00, 8'h02, 0, "status_to");
        access(S_WR, 23'h020801, 8'h02, 8'h00, 0, "status_clr_to");
        check("status_clr_to_irq", err_irq, 1'b0);
        access(S_RD, 23'h020801, 8'h00, 8'h00, 0, "status_clr_rd");

        // Three FIFO pushes, the third one while the FIFO is full.
        w0 = wen_cycles; p0 = wen_pulses;
        access(S_WR, 23'h020800, 8'h11, 8'h00, 0, "push1");
        check("push1_wen", ack_wen, 1'b1);
        check("push1_wdata", ack_wdata, 8'h11);
        access(S_WR, 23'h020800, 8'h22, 8'h00, 0, "push2");
        check("push2_wen", ack_wen, 1'b1);
        check("push2_wdata", ack_wdata, 8'h22);
        fifo_full = 1'b1;
        access(S_WR, 23'h020800, 8'h33, 8'h00, 0, "push3");
        check("push3_wen", ack_wen, 1'b0);
        check("push_pulses", wen_pulses - p0, 2);
        check("push_cycles", wen_cycles - w0, 2);
        check("push_ovf_irq", err_irq, 1'b1);
        access(S_RD, 23'h020801, 8'h00, 8'h05, 0, "status_ovf");
        fifo_full = 1'b0;
        access(S_WR, 23'h020801, 8'h04, 8'h00, 0, "status_clr_ovf");
        check("status_clr_ovf_irq", err_irq, 1'b0);

        // Reset in the middle of a RAM access that would never complete.
        ram_lat = 0;
        memaddr_comb = 23'h000300;
        memrd_comb   = 1'b1;
        repeat (5) @(posedge cpuclk);
        #1;
        check("abort_busy_strobe", ram_rd, 1'b1);
        rstn = 1'b0;
        memrd_comb = 1'b0;
        #1;
        check("abort_outputs", {memack, mempsack, apb_rd, apb_wr, ram_rd, ram_wr, fifo_wen, err_irq}, 8'h00);
        check("abort_datai", memdatai, 8'h00);
        check("abort_regs", regs_q, 64'h0);
        @(negedge cpuclk);
        rstn = 1'b1;
        begin
            int acks = 0;
            repeat (3) begin
                @(posedge cpuclk);
                #1;
                acks += int'(memack | mempsack);
            end
            check("abort_no_ack", acks, 0);
        end
        access(S_RD, 23'h020802, 8'h00, 8'h00, 0, "post_reset_reg");
        ram_lat = 1; ram_data = 8'h42;
        access(S_RD, 23'h000300, 8'h00, 8'h42, 0, "post_reset_ram");
        check("post_reset_ram_lat", lat, 2);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
